inst_fetch_stk: RTL and testbench
=================================

Name: inst_fetch_stk

Overview:
Parametrised next-generation program counter / instruction-fetch block for the 9-bit-ISA processor. Generalises PC width and the number of selectable program entry points. Adds a hardware return-address stack (call/return), signed relative branching, stall, and a halt/done handshake to the test bench. Sits at the front of the datapath and drives the instruction ROM address.

Parameters:
T, 10, PC width in bits (4..32).
NPROG, 3, number of selectable programs.
START_ADDRS, {10'd0,10'd0,10'd0}, packed NPROG*T vector. Entry i (bits i*T +: T) is the start PC of program i.
D, 4, return-stack depth (1..16).

Ports:
Clk  in  1  clock; all state changes on posedge.
Reset  in  1  synchronous, active-high reset.
Start  in  1  test-bench request: load and hold the selected program start.
ProgSel  in  $clog2(NPROG) (min 1)  program index, sampled while Start=1.
Stall  in  1  hold PC and stack this cycle (RUN only).
Halt  in  1  decoded halt instruction.
BranchAbs  in  1  conditional absolute jump to Target.
BranchRel  in  1  conditional relative jump to PC+signed(Target).
Call  in  1  unconditional call: push PC+1, jump to Target.
Ret  in  1  unconditional return: pop into PC.
ALU_flag  in  1  branch condition; drive 1 for unconditional branches.
Target  in  T  jump target or two's-complement offset.
ProgCtr  out  T  program counter register.
Done  out  1  high while in DONE.
StkOvf  out  1  sticky: Call issued with the stack full.
StkUnf  out  1  sticky: Ret issued with the stack empty.
StkDepth  out  $clog2(D+1)  current stack occupancy.

Behaviour:
- Reset (highest priority):
  - state=ARM; ProgCtr=START_ADDRS[0].
  - Done=0; StkOvf=0; StkUnf=0; StkDepth=0.
  - Reset asserted mid-run aborts everything the same way.
- Start=1, any state (second priority):
  - ProgCtr<=START_ADDRS[ProgSel]; ProgSel>=NPROG selects entry 0.
  - Stack cleared; StkOvf/StkUnf cleared; state<=ARM.
- ARM, Start=0: state<=RUN; ProgCtr unchanged, so the start address is the first fetch.
- RUN, one action per cycle, in priority order:
  1. Halt: state<=DONE, ProgCtr held.
  2. Stall: all state held; every other strobe ignored.
  3. Ret:
     - Depth>0: ProgCtr<=top entry, pop.
     - Depth=0: StkUnf<=1, ProgCtr<=ProgCtr+1.
  4. Call:
     - Depth<D: push ProgCtr+1, ProgCtr<=Target.
     - Depth=D: StkOvf<=1, no push, ProgCtr<=ProgCtr+1. The stack is not corrupted.
  5. BranchAbs & ALU_flag: ProgCtr<=Target.
  6. BranchRel & ALU_flag: ProgCtr<=ProgCtr+Target, with Target signed, result mod 2^T.
  7. Otherwise: ProgCtr<=ProgCtr+1, mod 2^T; all-ones wraps to 0.
- A branch strobe with ALU_flag=0 falls through to increment.
- The pushed return address PC+1 also wraps mod 2^T.
- DONE: ProgCtr and stack held; Done=1. Only Start or Reset leaves DONE.
- Latency: every PC update takes effect one cycle after the strobe; no combinational path from inputs to ProgCtr.
- Push and pop never occur in the same cycle; the priority order guarantees this.

Decomposition:
- Package fetch_pkg:
  - typedef enum logic [1:0] {ARM, RUN, DONE} fetch_state_t.
  - Action-priority encoding enum used for the next-PC mux select.
- Sub-module ret_stack #(T,D):
  - Synchronous LIFO with push, pop, clear, top, depth, full, empty.
  - Clear overrides push/pop.

Test Plan:
1. Reset; Start=1 with ProgSel=2 (START_ADDRS[2]=0x40) for 2 cycles; release -> ProgCtr=0x40 in ARM, then 0x41, 0x42 on successive cycles.
2. At PC=0x10, Call Target=0x80 -> PC=0x80, StkDepth=1. Run 3 cycles, then Ret -> PC=0x11, StkDepth=0.
3. With D=4, issue 5 nested Calls -> StkOvf=1 on the 5th, PC=prev+1, StkDepth stays 4. Then 5 Rets -> last Ret sets StkUnf=1.
4. At PC=0x20, BranchRel with Target=10'h3F8 (-8) and ALU_flag=1 -> PC=0x18. Same with ALU_flag=0 -> PC=0x21.
5. At PC=0x3FF, no strobes -> PC=0x000. Stall+BranchAbs together -> PC held. Halt+Call together -> DONE, Done=1, StkDepth unchanged.
6. In DONE, or mid-Call-nesting, assert Reset -> ARM, PC=START_ADDRS[0], Done=0, StkDepth=0, flags clear.

Source files
------------

// File: rtl/inst_fetch_stk_pkg.sv
// Shared types for the instruction-fetch block: FSM states and the
// per-cycle action code that selects the next program counter.
package fetch_pkg;

  typedef enum logic [1:0] {
    ARM,
    RUN,
    DONE
  } fetch_state_t;

  typedef enum logic [3:0] {
    ACT_HOLD,
    ACT_HALT,
    ACT_STALL,
    ACT_RET,
    ACT_RET_UNF,
    ACT_CALL,
    ACT_CALL_OVF,
    ACT_BR_ABS,
    ACT_BR_REL,
    ACT_INC
  } fetch_act_t;

endpackage

// File: rtl/inst_fetch_stk_if.sv
// Control strobes and status of the fetch block, bundled for the datapath
// (master) and the fetch unit itself (slave).
interface inst_fetch_stk_if #(
  parameter int unsigned T     = 10,
  parameter int unsigned NPROG = 3,
  parameter int unsigned D     = 4
);
  localparam int unsigned PSW = (NPROG > 1) ? $clog2(NPROG) : 1;
  localparam int unsigned DW  = $clog2(D + 1);

  logic           Start;
  logic [PSW-1:0] ProgSel;
  logic           Stall;
  logic           Halt;
  logic           BranchAbs;
  logic           BranchRel;
  logic           Call;
  logic           Ret;
  logic           ALU_flag;
  logic [T-1:0]   Target;
  logic [T-1:0]   ProgCtr;
  logic           Done;
  logic           StkOvf;
  logic           StkUnf;
  logic [DW-1:0]  StkDepth;

  modport master (
    output Start, ProgSel, Stall, Halt, BranchAbs, BranchRel, Call, Ret,
           ALU_flag, Target,
    input  ProgCtr, Done, StkOvf, StkUnf, StkDepth
  );

  modport slave (
    input  Start, ProgSel, Stall, Halt, BranchAbs, BranchRel, Call, Ret,
           ALU_flag, Target,
    output ProgCtr, Done, StkOvf, StkUnf, StkDepth
  );

endinterface

// File: rtl/inst_fetch_stk_ret_stack.sv
// Return-address LIFO. Push/pop are ignored when full/empty; clear wins
// over both so a program restart always begins with an empty stack.
module ret_stack #(
  parameter  int unsigned T  = 10,
  parameter  int unsigned D  = 4,
  localparam int unsigned DW = $clog2(D + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [T-1:0]  wdata_i,
  output logic [T-1:0]  top_o,
  output logic [DW-1:0] depth_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int unsigned IW = (D > 1) ? $clog2(D) : 1;

  logic [T-1:0]  mem_q [D];
  logic [DW-1:0] depth_q;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (depth_q == DW'(D));
  assign empty_o = (depth_q == '0);
  assign do_push = push_i && !full_o && !clear_i && !Reset;
  assign do_pop  = pop_i && !empty_o && !clear_i && !Reset;
  assign wr_idx  = IW'(depth_q);
  assign top_idx = IW'(depth_q - DW'(1));
  assign top_o   = mem_q[top_idx];
  assign depth_o = depth_q;

  always_ff @(posedge Clk) begin
    if (do_push) mem_q[wr_idx] <= wdata_i;
  end

  always_ff @(posedge Clk) begin
    if (Reset || clear_i) depth_q <= '0;
    else if (do_push)     depth_q <= depth_q + DW'(1);
    else if (do_pop)      depth_q <= depth_q - DW'(1);
  end

endmodule

// File: rtl/inst_fetch_stk.sv
// Program counter / fetch unit with program select, call/return stack,
// absolute and signed-relative branches, stall and halt handshake.
module inst_fetch_stk
  import fetch_pkg::*;
#(
  parameter int unsigned         T           = 10,
  parameter int unsigned         NPROG       = 3,
  parameter logic [NPROG*T-1:0]  START_ADDRS = '0,
  parameter int unsigned         D           = 4
) (
  input logic              Clk,
  input logic              Reset,
  inst_fetch_stk_if.slave  bus
);
  localparam int unsigned PSW = (NPROG > 1) ? $clog2(NPROG) : 1;
  localparam int unsigned DW  = $clog2(D + 1);

  fetch_state_t  state_q;
  fetch_act_t    act;
  logic [T-1:0]  pc_q, pc_d, pc_inc, start_pc, stk_top;
  logic [DW-1:0] stk_depth;
  logic          stk_full, stk_empty;
  logic          done_q, ovf_q, unf_q;

  assign pc_inc = pc_q + T'(1);

  // Out-of-range selects fall back to entry 0.
  always_comb begin
    start_pc = START_ADDRS[T-1:0];
    for (int unsigned i = 0; i < NPROG; i++) begin
      if (bus.ProgSel == PSW'(i)) start_pc = START_ADDRS[i*T +: T];
    end
  end

  always_comb begin
    act = ACT_HOLD;
    if (state_q == RUN) begin
      if (bus.Halt)                         act = ACT_HALT;
      else if (bus.Stall)                   act = ACT_STALL;
      else if (bus.Ret)                     act = stk_empty ? ACT_RET_UNF : ACT_RET;
      else if (bus.Call)                    act = stk_full ? ACT_CALL_OVF : ACT_CALL;
      else if (bus.BranchAbs && bus.ALU_flag) act = ACT_BR_ABS;
      else if (bus.BranchRel && bus.ALU_flag) act = ACT_BR_REL;
      else                                  act = ACT_INC;
    end
  end

  always_comb begin
    pc_d = pc_q;
    unique case (act)
      ACT_RET:                           pc_d = stk_top;
      ACT_CALL, ACT_BR_ABS:              pc_d = bus.Target;
      ACT_BR_REL:                        pc_d = pc_q + bus.Target;
      ACT_RET_UNF, ACT_CALL_OVF, ACT_INC: pc_d = pc_inc;
      default:                           pc_d = pc_q;
    endcase
  end

  ret_stack #(
    .T (T),
    .D (D)
  ) u_stack (
    .Clk     (Clk),
    .Reset   (Reset),
    .clear_i (bus.Start),
    .push_i  (act == ACT_CALL),
    .pop_i   (act == ACT_RET),
    .wdata_i (pc_inc),
    .top_o   (stk_top),
    .depth_o (stk_depth),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ARM;
      pc_q    <= START_ADDRS[T-1:0];
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (bus.Start) begin
      state_q <= ARM;
      pc_q    <= start_pc;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ARM: state_q <= RUN;
        RUN: begin
          pc_q <= pc_d;
          if (act == ACT_HALT) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
          if (act == ACT_RET_UNF)  unf_q <= 1'b1;
          if (act == ACT_CALL_OVF) ovf_q <= 1'b1;
        end
        DONE: state_q <= DONE;
        default: state_q <= ARM;
      endcase
    end
  end

  assign bus.ProgCtr  = pc_q;
  assign bus.Done     = done_q;
  assign bus.StkOvf   = ovf_q;
  assign bus.StkUnf   = unf_q;
  assign bus.StkDepth = stk_depth;

endmodule

// File: tb/tb_inst_fetch_stk.sv
// Directed self-checking bench for inst_fetch_stk (T=10, NPROG=3, D=4).
module tb_inst_fetch_stk;
  localparam int unsigned T = 10;
  localparam int unsigned NPROG = 3;
  localparam int unsigned D = 4;
  localparam logic [NPROG*T-1:0] SA = {10'h040, 10'h020, 10'h010};

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  inst_fetch_stk_if #(.T(T), .NPROG(NPROG), .D(D)) bus ();

  inst_fetch_stk #(.T(T), .NPROG(NPROG), .START_ADDRS(SA), .D(D)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    bus.Start = 0; bus.Stall = 0; bus.Halt = 0; bus.BranchAbs = 0;
    bus.BranchRel = 0; bus.Call = 0; bus.Ret = 0; bus.ALU_flag = 0;
    bus.Target = '0;
  endtask

  task automatic start_prog(input logic [1:0] sel);
    idle();
    bus.Start = 1; bus.ProgSel = sel;
    step();
    bus.Start = 0;
    step();
  endtask

  task automatic test_reset();
    idle(); bus.ProgSel = 0;
    Reset = 1;
    step(); step();
    n_cmp++; if (bus.ProgCtr !== 10'h010) begin n_err++; $display("FAIL reset_pc: got %h want %h", bus.ProgCtr, 10'h010); end
    n_cmp++; if (bus.Done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.Done); end
    n_cmp++; if (bus.StkOvf !== 1'b0 || bus.StkUnf !== 1'b0) begin n_err++; $display("FAIL reset_flags: got %b%b want 00", bus.StkOvf, bus.StkUnf); end
    n_cmp++; if (bus.StkDepth !== 3'd0) begin n_err++; $display("FAIL reset_depth: got %0d want 0", bus.StkDepth); end
    Reset = 0;
  endtask

  task automatic test_start();
    idle();
    bus.Start = 1; bus.ProgSel = 2;
    step(); step();
    n_cmp++; if (bus.ProgCtr !== 10'h040) begin n_err++; $display("FAIL start_load: got %h want %h", bus.ProgCtr, 10'h040); end
    bus.Start = 0;
    step();
    n_cmp++; if (bus.ProgCtr !== 10'h040) begin n_err++; $display("FAIL arm_hold: got %h want %h", bus.ProgCtr, 10'h040); end
    step();
    n_cmp++; if (bus.ProgCtr !== 10'h041) begin n_err++; $display("FAIL run_inc1: got %h want %h", bus.ProgCtr, 10'h041); end
    step();
    n_cmp++; if (bus.ProgCtr !== 10'h042) begin n_err++; $display("FAIL run_inc2: got %h want %h", bus.ProgCtr, 10'h042); end
    start_prog(2'd3);
    n_cmp++; if (bus.ProgCtr !== 10'h010) begin n_err++; $display("FAIL progsel_oob: got %h want %h", bus.ProgCtr, 10'h010); end
  endtask

  task automatic test_call_ret();
    start_prog(2'd0);
    bus.Call = 1; bus.Target = 10'h080;
    step();
    idle();
    n_cmp++; if (bus.ProgCtr !== 10'h080) begin n_err++; $display("FAIL call_pc: got %h want %h", bus.ProgCtr, 10'h080); end
    n_cmp++; if (bus.StkDepth !== 3'd1) begin n_err++; $display("FAIL call_depth: got %0d want 1", bus.StkDepth); end
    step(); step(); step();
    n_cmp++; if (bus.ProgCtr !== 10'h083) begin n_err++; $display("FAIL callee_run: got %h want %h", bus.ProgCtr, 10'h083); end
    bus.Ret = 1;
    step();
    idle();
    n_cmp++; if (bus.ProgCtr !== 10'h011) begin n_err++; $display("FAIL ret_pc: got %h want %h", bus.ProgCtr, 10'h011); end
    n_cmp++; if (bus.StkDepth !== 3'd0) begin n_err++; $display("FAIL ret_depth: got %0d want 0", bus.StkDepth); end
  endtask

  task automatic test_overflow();
    logic [9:0] tgt [5];
    logic [9:0] ret_pc [4];
    tgt = '{10'h100, 10'h200, 10'h300, 10'h380, 10'h050};
    ret_pc = '{10'h301, 10'h201, 10'h101, 10'h011};
    start_prog(2'd0);
    for (int i = 0; i < 4; i++) begin
      bus.Call = 1; bus.Target = tgt[i];
      step();
    end
    n_cmp++; if (bus.ProgCtr !== 10'h380 || bus.StkDepth !== 3'd4) begin n_err++; $display("FAIL nest4: got pc %h depth %0d want 380 4", bus.ProgCtr, bus.StkDepth); end
    bus.Target = tgt[4];
    step();
    idle();
    n_cmp++; if (bus.StkOvf !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", bus.StkOvf); end
    n_cmp++; if (bus.ProgCtr !== 10'h381 || bus.StkDepth !== 3'd4) begin n_err++; $display("FAIL ovf_pc: got pc %h depth %0d want 381 4", bus.ProgCtr, bus.StkDepth); end
    for (int i = 0; i < 4; i++) begin
      bus.Ret = 1;
      step();
      n_cmp++; if (bus.ProgCtr !== ret_pc[i]) begin n_err++; $display("FAIL ret_chain%0d: got %h want %h", i, bus.ProgCtr, ret_pc[i]); end
    end
    n_cmp++; if (bus.StkUnf !== 1'b0 || bus.StkDepth !== 3'd0) begin n_err++; $display("FAIL pre_unf: got unf %b depth %0d want 0 0", bus.StkUnf, bus.StkDepth); end
    step();
    idle();
    n_cmp++; if (bus.StkUnf !== 1'b1 || bus.ProgCtr !== 10'h012) begin n_err++; $display("FAIL unf: got unf %b pc %h want 1 012", bus.StkUnf, bus.ProgCtr); end
    n_cmp++; if (bus.StkOvf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", bus.StkOvf); end
    start_prog(2'd0);
    n_cmp++; if (bus.StkOvf !== 1'b0 || bus.StkUnf !== 1'b0) begin n_err++; $display("FAIL start_clr_flags: got %b%b want 00", bus.StkOvf, bus.StkUnf); end
  endtask

  task automatic test_branch();
    start_prog(2'd1);
    bus.BranchRel = 1; bus.ALU_flag = 1; bus.Target = 10'h3F8;
    step();
    idle();
    n_cmp++; if (bus.ProgCtr !== 10'h018) begin n_err++; $display("FAIL rel_neg: got %h want %h", bus.ProgCtr, 10'h018); end
    start_prog(2'd1);
    bus.BranchRel = 1; bus.ALU_flag = 0; bus.Target = 10'h3F8;
    step();
    n_cmp++; if (bus.ProgCtr !== 10'h021) begin n_err++; $display("FAIL rel_nottaken: got %h want %h", bus.ProgCtr, 10'h021); end
    idle();
    bus.BranchAbs = 1; bus.ALU_flag = 0; bus.Target = 10'h100;
    step();
    n_cmp++; if (bus.ProgCtr !== 10'h022) begin n_err++; $display("FAIL abs_nottaken: got %h want %h", bus.ProgCtr, 10'h022); end
    idle();
    bus.BranchRel = 1; bus.ALU_flag = 1; bus.Target = 10'h005;
    step();
    idle();
    n_cmp++; if (bus.ProgCtr !== 10'h027) begin n_err++; $display("FAIL rel_pos: got %h want %h", bus.ProgCtr, 10'h027); end
  endtask

  task automatic test_wrap();
    bus.BranchAbs = 1; bus.ALU_flag = 1; bus.Target = 10'h3FF;
    step();
    idle();
    n_cmp++; if (bus.ProgCtr !== 10'h3FF) begin n_err++; $display("FAIL abs_taken: got %h want %h", bus.ProgCtr, 10'h3FF); end
    step();
    n_cmp++; if (bus.ProgCtr !== 10'h000) begin n_err++; $display("FAIL pc_wrap: got %h want %h", bus.ProgCtr, 10'h000); end
    bus.BranchAbs = 1; bus.ALU_flag = 1; bus.Target = 10'h3FF;
    step();
    idle();
    bus.Call = 1; bus.Target = 10'h005;
    step();
    idle();
    bus.Ret = 1;
    step();
    idle();
    n_cmp++; if (bus.ProgCtr !== 10'h000) begin n_err++; $display("FAIL push_wrap: got %h want %h", bus.ProgCtr, 10'h000); end
  endtask

  task automatic test_stall_halt();
    bus.Call = 1; bus.Target = 10'h060;
    step();
    idle();
    bus.Stall = 1; bus.BranchAbs = 1; bus.ALU_flag = 1; bus.Target = 10'h077;
    step();
    n_cmp++; if (bus.ProgCtr !== 10'h060) begin n_err++; $display("FAIL stall_abs: got %h want %h", bus.ProgCtr, 10'h060); end
    idle();
    bus.Stall = 1; bus.Ret = 1;
    step();
    idle();
    n_cmp++; if (bus.ProgCtr !== 10'h060 || bus.StkDepth !== 3'd1) begin n_err++; $display("FAIL stall_ret: got pc %h depth %0d want 060 1", bus.ProgCtr, bus.StkDepth); end
    bus.Halt = 1; bus.Call = 1; bus.Target = 10'h090;
    step();
    idle();
    n_cmp++; if (bus.Done !== 1'b1 || bus.ProgCtr !== 10'h060 || bus.StkDepth !== 3'd1) begin n_err++; $display("FAIL halt_call: got done %b pc %h depth %0d want 1 060 1", bus.Done, bus.ProgCtr, bus.StkDepth); end
    bus.BranchAbs = 1; bus.ALU_flag = 1; bus.Target = 10'h077;
    step(); step();
    idle();
    n_cmp++; if (bus.Done !== 1'b1 || bus.ProgCtr !== 10'h060) begin n_err++; $display("FAIL done_hold: got done %b pc %h want 1 060", bus.Done, bus.ProgCtr); end
    bus.Start = 1; bus.ProgSel = 2;
    step();
    bus.Start = 0;
    n_cmp++; if (bus.Done !== 1'b0 || bus.ProgCtr !== 10'h040 || bus.StkDepth !== 3'd0) begin n_err++; $display("FAIL done_restart: got done %b pc %h depth %0d want 0 040 0", bus.Done, bus.ProgCtr, bus.StkDepth); end
    step();
  endtask

  task automatic test_reset_mid();
    bus.Ret = 1;
    step();
    idle();
    bus.Call = 1; bus.Target = 10'h200;
    step();
    bus.Target = 10'h210;
    step();
    idle();
    n_cmp++; if (bus.StkUnf !== 1'b1 || bus.StkDepth !== 3'd2) begin n_err++; $display("FAIL pre_reset: got unf %b depth %0d want 1 2", bus.StkUnf, bus.StkDepth); end
    Reset = 1;
    step();
    Reset = 0;
    n_cmp++; if (bus.ProgCtr !== 10'h010 || bus.StkDepth !== 3'd0 || bus.StkUnf !== 1'b0) begin n_err++; $display("FAIL reset_nest: got pc %h depth %0d unf %b want 010 0 0", bus.ProgCtr, bus.StkDepth, bus.StkUnf); end
    start_prog(2'd0);
    bus.Call = 1; bus.Target = 10'h030;
    step();
    idle();
    bus.Halt = 1;
    step();
    idle();
    Reset = 1;
    step();
    Reset = 0;
    n_cmp++; if (bus.Done !== 1'b0 || bus.ProgCtr !== 10'h010 || bus.StkDepth !== 3'd0) begin n_err++; $display("FAIL reset_done: got done %b pc %h depth %0d want 0 010 0", bus.Done, bus.ProgCtr, bus.StkDepth); end
    step();
    n_cmp++; if (bus.ProgCtr !== 10'h010) begin n_err++; $display("FAIL post_reset_arm: got %h want %h", bus.ProgCtr, 10'h010); end
    step();
    n_cmp++; if (bus.ProgCtr !== 10'h011) begin n_err++; $display("FAIL post_reset_run: got %h want %h", bus.ProgCtr, 10'h011); end
  endtask

  initial begin
    idle();
    bus.ProgSel = 0;
    test_reset();
    test_start();
    test_call_ret();
    test_overflow();
    test_branch();
    test_wrap();
    test_stall_halt();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
